// File: rtl/eth_tx_pkg.sv
// Shared types and helpers for the Ethernet transmit frame scheduler.
// Header word layout lives here so the scheduler and any future framers agree on it.
package eth_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_PAD
    } state_t;

    localparam int HDR_WORDS         = 4;
    localparam int MIN_PAYLOAD_WORDS = 11;

    // Word idx of the raw Ethernet header; bits [31:24] go on the wire first.
    function automatic logic [31:0] hdr_word(
        input logic [1:0]  idx,
        input logic [47:0] dst,
        input logic [47:0] src,
        input logic [15:0] etype,
        input logic [15:0] seq
    );
        logic [31:0] word;
        case (idx)
            2'd0:    word = dst[47:16];
            2'd1:    word = {dst[15:0], src[47:32]};
            2'd2:    word = src[31:0];
            default: word = {etype, seq};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/eth_tx_flush_timer.sv
// Flush timer: counts up while enabled and holds at its terminal count until cleared,
// so a timeout seen while new frames are disabled is not lost.
module eth_tx_flush_timer #(
    parameter int TIMEOUT_CYCLES = 125000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic terminal
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count_en && !terminal) begin
            count <= count + 1'b1;
        end
    end

    assign terminal = (count == LAST);

endmodule

// File: rtl/eth_tx_frame_scheduler.sv
// Drains TDC words from a show-ahead FIFO into raw Ethernet frames on the TSE MAC Avalon-ST port.
// Optional macro ETH_TX_SEQNUM_EN puts a 16-bit frame sequence number into header word 3.
module eth_tx_frame_scheduler
    import eth_tx_pkg::*;
#(
    parameter int          WORDS_PER_FRAME = 256,
    parameter int          TIMEOUT_CYCLES  = 125000,
    parameter int          USEDW_W         = 10,
    parameter logic [47:0] DST_MAC         = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC         = 48'h020000000001,
    parameter logic [15:0] ETHERTYPE       = 16'h88B5
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic               enable,
    input  logic [31:0]        fifo_q,
    input  logic               fifo_empty,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic               fifo_rdreq,
    output logic [31:0]        tx_data,
    output logic               tx_startofpacket,
    output logic               tx_endofpacket,
    output logic [1:0]         tx_empty,
    output logic               tx_error,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic [31:0]        frames_sent
);

    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] WPF_C      = CNT_W'(WORDS_PER_FRAME);
    localparam logic [CNT_W-1:0] HDR_LAST_C = CNT_W'(HDR_WORDS - 1);
    localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_PAYLOAD_WORDS);
    localparam logic [CNT_W-1:0] MIN_LAST_C = CNT_W'(MIN_PAYLOAD_WORDS - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] beat_cnt, beat_next;
    logic [CNT_W-1:0] n_words, n_next;
    logic [15:0]      seq_val;
    logic             timer_terminal;
    logic             full_batch;
    logic             launch;
    logic             pay_last;
    logic             eop_accept;

    assign full_batch = (32'(fifo_usedw) >= 32'(WORDS_PER_FRAME));
    assign launch     = (state == ST_IDLE) && enable && (fifo_usedw != '0)
                        && (full_batch || timer_terminal);
    assign pay_last   = (beat_cnt == n_words - 1'b1);
    assign eop_accept = tx_valid && tx_ready && tx_endofpacket;

    eth_tx_flush_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_flush_timer (
        .clk      (clk_clk),
        .reset    (reset_reset),
        .clear    (fifo_empty || eop_accept),
        .count_en ((state == ST_IDLE) && !fifo_empty),
        .terminal (timer_terminal)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state       <= ST_IDLE;
            beat_cnt    <= '0;
            n_words     <= '0;
            frames_sent <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_next;
            n_words  <= n_next;
            if (eop_accept) begin
                frames_sent <= frames_sent + 32'd1;
            end
        end
    end

`ifdef ETH_TX_SEQNUM_EN
    logic [15:0] seq;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            seq <= '0;
        end else if (eop_accept) begin
            seq <= seq + 16'd1;
        end
    end

    assign seq_val = seq;
`else
    assign seq_val = 16'h0000;
`endif

    // Beat outputs decode straight from the state registers; PAY forwards the FIFO
    // head and pops it on the same handshake so payload adds no latency.
    always_comb begin
        state_next       = state;
        beat_next        = beat_cnt;
        n_next           = n_words;
        tx_valid         = 1'b0;
        tx_data          = '0;
        tx_startofpacket = 1'b0;
        tx_endofpacket   = 1'b0;
        fifo_rdreq       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (launch) begin
                    state_next = ST_HDR;
                    beat_next  = '0;
                    n_next     = full_batch ? WPF_C : CNT_W'(fifo_usedw);
                end
            end
            ST_HDR: begin
                tx_valid         = 1'b1;
                tx_data          = hdr_word(beat_cnt[1:0], DST_MAC, SRC_MAC, ETHERTYPE, seq_val);
                tx_startofpacket = (beat_cnt == '0);
                if (tx_ready) begin
                    if (beat_cnt == HDR_LAST_C) begin
                        state_next = ST_PAY;
                        beat_next  = '0;
                    end else begin
                        beat_next = beat_cnt + 1'b1;
                    end
                end
            end
            ST_PAY: begin
                tx_valid       = 1'b1;
                tx_data        = fifo_q;
                fifo_rdreq     = tx_ready;
                tx_endofpacket = pay_last && (n_words >= MIN_C);
                if (tx_ready) begin
                    if (!pay_last) begin
                        beat_next = beat_cnt + 1'b1;
                    end else if (n_words < MIN_C) begin
                        state_next = ST_PAD;
                        beat_next  = beat_cnt + 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_PAD: begin
                // beat_cnt keeps counting total payload words so padding stops at the minimum.
                tx_valid       = 1'b1;
                tx_endofpacket = (beat_cnt == MIN_LAST_C);
                if (tx_ready) begin
                    if (beat_cnt == MIN_LAST_C) begin
                        state_next = ST_IDLE;
                    end else begin
                        beat_next = beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state != ST_IDLE);
    assign tx_empty = 2'b00;
    assign tx_error = 1'b0;

endmodule

// File: tb/tb_eth_tx_frame_scheduler.sv
// Directed bench for eth_tx_frame_scheduler: a show-ahead FIFO model feeds the DUT and every
// accepted beat is recorded, then compared against hand-built frame images.
module tb_eth_tx_frame_scheduler;

    localparam int WPF     = 256;
    localparam int TIMEOUT = 40;
`ifdef ETH_TX_SEQNUM_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_reset;
    logic        enable;
    logic [31:0] fifo_q;
    logic        fifo_empty;
    logic [9:0]  fifo_usedw;
    logic        fifo_rdreq;
    logic [31:0] tx_data;
    logic        tx_startofpacket;
    logic        tx_endofpacket;
    logic [1:0]  tx_empty;
    logic        tx_error;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [31:0] frames_sent;

    logic [31:0] fifo_mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        fifo_flush;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic        toggle_ready;

    logic [31:0] beat_data [$];
    logic        beat_sop  [$];
    logic        beat_eop  [$];
    int          sop_cyc   [$];

    logic        prev_stall = 1'b0;
    logic        prev_eop_acc = 1'b0;
    logic [31:0] prev_data = '0;
    logic [2:0]  prev_flags = '0;

    always #4 clk = ~clk;

    eth_tx_frame_scheduler #(
        .WORDS_PER_FRAME (WPF),
        .TIMEOUT_CYCLES  (TIMEOUT),
        .USEDW_W         (10),
        .DST_MAC         (48'hFFFFFFFFFFFF),
        .SRC_MAC         (48'h020000000001),
        .ETHERTYPE       (16'h88B5)
    ) dut (
        .clk_clk          (clk),
        .reset_reset      (reset_reset),
        .enable           (enable),
        .fifo_q           (fifo_q),
        .fifo_empty       (fifo_empty),
        .fifo_usedw       (fifo_usedw),
        .fifo_rdreq       (fifo_rdreq),
        .tx_data          (tx_data),
        .tx_startofpacket (tx_startofpacket),
        .tx_endofpacket   (tx_endofpacket),
        .tx_empty         (tx_empty),
        .tx_error         (tx_error),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .busy             (busy),
        .frames_sent      (frames_sent)
    );

    assign fifo_q     = fifo_mem[rd_ptr[9:0]];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_usedw = 10'(wr_ptr - rd_ptr);

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rdreq) begin
            rd_ptr <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] exp_seq(input int k);
        if (SEQ_ON) return 16'(k);
        return 16'h0000;
    endfunction

    task automatic push(input logic [31:0] start, input int count);
        for (int i = 0; i < count; i++) begin
            fifo_mem[wr_ptr[9:0]] = start + 32'(i);
            wr_ptr++;
        end
    endtask

    // Negedge sampling: record accepted beats and check the handshake rules each cycle.
    task automatic sample();
        if (!reset_reset) begin
            if (prev_stall) begin
                check("stall_data", tx_data, prev_data);
                check("stall_flags", {tx_valid, tx_startofpacket, tx_endofpacket}, prev_flags);
            end
            if (prev_eop_acc) begin
                check("idle_gap", tx_valid, 1'b0);
            end
        end
        if (fifo_rdreq) begin
            check("rdreq_qual", {tx_valid, tx_ready, fifo_empty}, 3'b110);
        end
        if (tx_valid && tx_ready) begin
            beat_data.push_back(tx_data);
            beat_sop.push_back(tx_startofpacket);
            beat_eop.push_back(tx_endofpacket);
            if (tx_startofpacket) sop_cyc.push_back(cyc);
        end
        prev_stall   = tx_valid && !tx_ready;
        prev_eop_acc = tx_valid && tx_ready && tx_endofpacket;
        prev_data    = tx_data;
        prev_flags   = {tx_valid, tx_startofpacket, tx_endofpacket};
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
        tx_ready = toggle_ready ? ~tx_ready : 1'b1;
    endtask

    task automatic wait_size(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (beat_data.size() < target && n < budget) begin
            step();
            n++;
        end
        check(tag, beat_data.size() >= target, 1'b1);
    endtask

    task automatic do_reset();
        reset_reset  = 1'b1;
        enable       = 1'b0;
        toggle_ready = 1'b0;
        tx_ready     = 1'b1;
        fifo_flush   = 1'b1;
        step();
        step();
        reset_reset  = 1'b0;
        fifo_flush   = 1'b0;
        step();
    endtask

    task automatic check_frame(input string tag, input int base, input int npay,
                               input logic [31:0] start, input logic [15:0] seq);
        int          total;
        logic [31:0] exp_d;
        total = 4 + ((npay < 11) ? 11 : npay);
        check({tag, "_len"}, beat_data.size() >= base + total, 1'b1);
        if (beat_data.size() >= base + total) begin
            for (int j = 0; j < total; j++) begin
                case (j)
                    0:       exp_d = 32'hFFFFFFFF;
                    1:       exp_d = 32'hFFFF0200;
                    2:       exp_d = 32'h00000001;
                    3:       exp_d = {16'h88B5, seq};
                    default: exp_d = (j - 4 < npay) ? start + 32'(j - 4) : 32'h0;
                endcase
                check({tag, "_data"}, beat_data[base + j], exp_d);
                check({tag, "_flags"}, {beat_sop[base + j], beat_eop[base + j]},
                      {j == 0, j == total - 1});
            end
        end
    endtask

    initial begin
        int base;
        int base2;
        int c0;
        int s0;
        int lat;

        reset_reset  = 1'b1;
        enable       = 1'b0;
        tx_ready     = 1'b1;
        toggle_ready = 1'b0;
        fifo_flush   = 1'b1;
        step();
        step();
        check("rst_valid", tx_valid, 1'b0);
        check("rst_sop", tx_startofpacket, 1'b0);
        check("rst_eop", tx_endofpacket, 1'b0);
        check("rst_data", tx_data, 32'h0);
        check("rst_rdreq", fifo_rdreq, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frames", frames_sent, 32'h0);
        check("rst_empty_err", {tx_empty, tx_error}, 3'b000);
        reset_reset = 1'b0;
        fifo_flush  = 1'b0;
        step();

        $display("[TB] test 1: full frame, ready held high");
        base = beat_data.size();
        push(32'h0, 256);
        enable = 1'b1;
        wait_size("t1_wait", base + 260, 1000);
        check_frame("t1", base, 256, 32'h0, exp_seq(0));
        check("t1_frames", frames_sent, 32'd1);
        step();
        check("t1_busy", busy, 1'b0);

        $display("[TB] test 2: full frame, ready toggling");
        do_reset();
        base = beat_data.size();
        toggle_ready = 1'b1;
        push(32'd1000, 256);
        enable = 1'b1;
        wait_size("t2_wait", base + 260, 2000);
        toggle_ready = 1'b0;
        check_frame("t2", base, 256, 32'd1000, exp_seq(0));
        check("t2_frames", frames_sent, 32'd1);

        $display("[TB] test 3: short batch flushed by timeout");
        do_reset();
        enable = 1'b1;
        base   = beat_data.size();
        s0     = sop_cyc.size();
        push(32'hA5A50000, 3);
        c0 = cyc;
        wait_size("t3_wait", base + 15, 300);
        lat = (sop_cyc.size() > s0) ? sop_cyc[s0] - c0 : -1;
        check("t3_latency", 64'(lat), 64'(TIMEOUT));
        check_frame("t3", base, 3, 32'hA5A50000, exp_seq(0));
        check("t3_frames", frames_sent, 32'd1);

        $display("[TB] test 4: 600 words, two full frames and one timed-out frame");
        do_reset();
        base = beat_data.size();
        s0   = sop_cyc.size();
        push(32'h0, 600);
        enable = 1'b1;
        wait_size("t4_wait", base + 612, 1500);
        check_frame("t4f0", base, 256, 32'd0, exp_seq(0));
        check_frame("t4f1", base + 260, 256, 32'd256, exp_seq(1));
        check_frame("t4f2", base + 520, 88, 32'd512, exp_seq(2));
        check("t4_frames", frames_sent, 32'd3);
        lat = (sop_cyc.size() >= s0 + 3) ? sop_cyc[s0 + 1] - sop_cyc[s0] : -1;
        check("t4_b2b_gap", 64'(lat), 64'd261);
        lat = (sop_cyc.size() >= s0 + 3) ? sop_cyc[s0 + 2] - sop_cyc[s0 + 1] : -1;
        check("t4_timeout_gap", 64'(lat), 64'(260 + TIMEOUT));

        $display("[TB] test 5: reset at payload beat 10");
        do_reset();
        enable = 1'b1;
        base   = beat_data.size();
        push(32'h0, 256);
        wait_size("t5_wait_mid", base + 14, 100);
        reset_reset = 1'b1;
        step();
        reset_reset = 1'b0;
        check("t5_valid", tx_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_frames", frames_sent, 32'd0);
        check("t5_trunc_len", beat_data.size(), base + 15);
        base2 = beat_data.size();
        wait_size("t5_wait_next", base2 + 249, 600);
        check_frame("t5", base2, 245, 32'd11, exp_seq(0));
        check("t5_frames_after", frames_sent, 32'd1);

        $display("[TB] test 6: enable dropped at header beat 2");
        do_reset();
        enable = 1'b1;
        base   = beat_data.size();
        push(32'h0, 256);
        wait_size("t6_wait_hdr", base + 2, 50);
        enable = 1'b0;
        push(32'd1000, 300);
        wait_size("t6_wait", base + 260, 600);
        check_frame("t6", base, 256, 32'd0, exp_seq(0));
        for (int i = 0; i < 3 * TIMEOUT; i++) step();
        check("t6_no_launch", beat_data.size(), base + 260);
        check("t6_frames", frames_sent, 32'd1);
        check("t6_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
